// File: rtl/rnd_pkg.sv
// Shared definitions for the LFSR randomness source and the segment-probability
// expander: FSM encoding, probability codes and the LFSR feedback taps.
package rnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } rnd_state_e;

  localparam logic [1:0] PROB_05 = 2'b00;
  localparam logic [1:0] PROB_06 = 2'b01;
  localparam logic [1:0] PROB_07 = 2'b10;
  localparam logic [1:0] PROB_09 = 2'b11;

  // Feedback is the MSB xor'ed with these fixed low taps; the expander uses the same set.
  localparam int LFSR_TAP_A = 3;
  localparam int LFSR_TAP_B = 2;
  localparam int LFSR_TAP_C = 0;

  localparam int LFSR_MIN_WIDTH = 5;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of the shared LFSR: shift left, feed back the
// xor of the MSB and the package taps into bit 0.
module lfsr_step
  import rnd_pkg::*;
#(
  parameter int RNDSIZE = 16
) (
  input  logic [RNDSIZE-1:0] state_i,
  output logic [RNDSIZE-1:0] next_o
);

  logic feedback;

  assign feedback = state_i[RNDSIZE-1] ^ state_i[LFSR_TAP_A]
                  ^ state_i[LFSR_TAP_B] ^ state_i[LFSR_TAP_C];

  assign next_o = {state_i[RNDSIZE-2:0], feedback};

endmodule

// File: rtl/lfsr_rnd_source.sv
// Seeded LFSR randomness source: discards WARMUP steps after each seed load,
// then offers one word per accepted valid/ready handshake.
module lfsr_rnd_source
  import rnd_pkg::*;
#(
  parameter int RNDSIZE = 16,
  parameter int WARMUP  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic [RNDSIZE-1:0] seed,
  input  logic [1:0]         prob_in,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [RNDSIZE-1:0] r,
  output logic [1:0]         probability,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  if (RNDSIZE < LFSR_MIN_WIDTH) begin : g_width_check
    $error("lfsr_rnd_source: RNDSIZE must be at least 5");
  end

  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int WLAST_I = (WARMUP > 0) ? WARMUP - 1 : 0;
  localparam logic [WCW-1:0] WLAST = WCW'(WLAST_I);

  rnd_state_e         state_q;
  logic [RNDSIZE-1:0] lfsr_q;
  logic [RNDSIZE-1:0] lfsr_next;
  logic [RNDSIZE-1:0] seed_load_d;
  logic [1:0]         prob_q;
  logic [15:0]        frame_q;
  logic [WCW-1:0]     wcnt_q;
  logic               seed_ready_q;
  logic               r_valid_q;
  logic               busy_q;
  logic               seed_hs;
  logic               r_hs;

  // Single stepper shared by warm-up and run; only one of them advances per cycle.
  lfsr_step #(.RNDSIZE(RNDSIZE)) u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next)
  );

  assign seed_load_d = (seed == '0) ? RNDSIZE'(1) : seed;
  assign seed_hs     = seed_valid && seed_ready_q;
  assign r_hs        = r_valid_q && r_ready;

  // A seed handshake outranks everything else, including a same-cycle word accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= RNDSIZE'(1);
      prob_q       <= PROB_05;
      frame_q      <= '0;
      wcnt_q       <= '0;
      seed_ready_q <= 1'b1;
      r_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else if (seed_hs) begin
      lfsr_q  <= seed_load_d;
      prob_q  <= prob_in;
      frame_q <= '0;
      wcnt_q  <= '0;
      if (WARMUP == 0) begin
        state_q      <= ST_RUN;
        seed_ready_q <= 1'b1;
        r_valid_q    <= 1'b1;
        busy_q       <= 1'b0;
      end else begin
        state_q      <= ST_WARMUP;
        seed_ready_q <= 1'b0;
        r_valid_q    <= 1'b0;
        busy_q       <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_WARMUP: begin
          lfsr_q <= lfsr_next;
          if (wcnt_q == WLAST) begin
            state_q      <= ST_RUN;
            seed_ready_q <= 1'b1;
            r_valid_q    <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (r_hs) begin
            lfsr_q  <= lfsr_next;
            frame_q <= frame_q + 16'd1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          seed_ready_q <= 1'b1;
          r_valid_q    <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign seed_ready  = seed_ready_q;
  assign r_valid     = r_valid_q;
  assign busy        = busy_q;
  assign r           = lfsr_q;
  assign probability = prob_q;
  assign frame_cnt   = frame_q;

endmodule

// File: doc/lfsr_rnd_source.md
# lfsr_rnd_source

Sequential randomness source feeding the segment-probability expander. It holds a seeded RNDSIZE-bit LFSR and a latched 2-bit probability code. After a configurable warm-up it presents one random word per frame on a valid/ready stream, advancing the LFSR exactly once per accepted word. The LFSR taps are identical to the expander's feedback polynomial, so both ends agree on the sequence.

## Interface
- `RNDSIZE`, default 16: LFSR and output word width; must be ≥ 5.
- `WARMUP`, default 32: LFSR steps discarded after each seed load; 0 is legal.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `seed_valid`  in  1: seed/probability load request.
- `seed_ready`  out  1: seed accepted when `seed_valid && seed_ready`.
- `seed`  in  RNDSIZE: initial LFSR state.
- `prob_in`  in  2: probability code latched with the seed (00 = 0.5, 01 = 0.6, 10 = 0.7, 11 = 0.9).
- `r_valid`  out  1: random word available.
- `r_ready`  in  1: downstream accepts the word.
- `r`  out  RNDSIZE: current LFSR state.
- `probability`  out  2: latched probability code.
- `frame_cnt`  out  16: number of accepted words since the last seed load.
- `busy`  out  1: high during WARMUP.

## Operation
- Step function: `next = {s[RNDSIZE-2:0], s[RNDSIZE-1]^s[3]^s[2]^s[0]}`.
- Zero-seed guard: a `seed` of all zeros loads as 1 (avoids LFSR lock-up).
- FSM states:
  - IDLE: `seed_ready=1`, `r_valid=0`. A seed handshake goes to WARMUP, or straight to RUN if `WARMUP==0`.
  - WARMUP: `seed_ready=0`, `busy=1`. The LFSR steps every cycle for WARMUP cycles, then the FSM moves to RUN.
  - RUN: `seed_ready=1`, `r_valid=1`. On `r_valid && r_ready` the LFSR steps once and `frame_cnt` increments.
- Seed load (any accepting state):
  - Latches `seed` (zero guarded) and `prob_in`.
  - Clears `frame_cnt` to 0.
  - Resets the warm-up counter.
- Simultaneous seed handshake and `r` handshake in RUN:
  - The word is consumed downstream.
  - The seed load wins the register update: state = new seed, `frame_cnt` = 0, next state WARMUP (or RUN if `WARMUP==0`).
- `frame_cnt` wraps from 0xFFFF to 0x0000.
- `r` and `probability` stay stable while `r_valid && !r_ready` (AXI-style hold).
- `r_valid` never drops in RUN except on a seed load with `WARMUP>0`.
- Values of `r` and `probability` outside RUN are don't-care but deterministic (current register contents).

## Timing
- Reset values:
  - State IDLE; LFSR = 1; `probability` = 00; `frame_cnt` = 0.
  - `r_valid` = 0, `busy` = 0, `seed_ready` = 1.
- Seed accepted at edge t:
  - `busy` = 1 from t+1 through t+WARMUP.
  - `r_valid` = 1 at t+1+WARMUP, with `r` = seed stepped WARMUP times.
- Throughput: one word per cycle with `r_ready` held high.
- All outputs are registered; no combinational path from `r_ready` or `seed_valid` to any output.
- `rst_n` asserted mid-WARMUP or mid-RUN forces reset values immediately (asynchronous). Operation resumes on the first rising edge after deassertion.

## Structure
- Shared package `rnd_pkg`:
  - FSM state encoding (IDLE/WARMUP/RUN).
  - Probability code constants PROB_05/06/07/09.
  - LFSR tap positions, so the expander can reuse them.
- Sub-module `lfsr_step`: combinational single-step next-state function, parameterised by RNDSIZE. Instantiated once for the datapath; the warm-up loop reuses the same instance.
- Warm-up counter width: `$clog2(WARMUP+1)`.

## Test plan
- Sequence check (RNDSIZE=16, WARMUP=0, `r_ready`=1): seed 0x0001, prob 10 → `r` = 0x0001, 0x0003, 0x0007, 0x000E on consecutive cycles; `probability` = 10; `frame_cnt` = 0, 1, 2, 3.
- Zero seed: seed 0x0000 → first `r` = 0x0001; the sequence then matches the previous scenario.
- Backpressure: with `r_valid` high, `r_ready` low for 5 cycles → `r` and `frame_cnt` unchanged. Raising `r_ready` steps the LFSR once per cycle.
- Warm-up (WARMUP=3): seed at t → `busy` high t+1..t+3, `seed_ready` low; `r_valid` at t+4 with `r` = 0x000E.
- Collision and wrap:
  - Seed and `r` handshakes in the same cycle → `frame_cnt` = 0 and `r` = new seed next cycle.
  - Force `frame_cnt` to 0xFFFF, accept one word → `frame_cnt` = 0x0000.
- Async reset mid-WARMUP → `r_valid`=0, `busy`=0, `seed_ready`=1 immediately, with no waiting for a clock edge.
